pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
//
// PURPOSE
//   Pulse-train generator: the emitting end of the count-event path.
//   Takes a pulse count N, a high time and a low time, then emits exactly N
//   pulses and counts them down to zero.
//   Signals completion with a one-cycle done strobe.
//   Feeds counter/event inputs in the lab designs and exercises them.
//
// PARAMETERS
//   WIDTH  8  width of pulse count i_count / o_remaining
//   PER_W  4  width of phase durations i_high / i_low (cycles)
//
// PORTS
//   i_clk        in   1      clock, rising edge
//   i_rstn       in   1      asynchronous active-low reset
//   i_count      in   WIDTH  number of pulses N, sampled on accepted start
//   i_high       in   PER_W  high-phase cycles H, sampled on start; 0 treated as 1
//   i_low        in   PER_W  low-phase cycles L, sampled on start; 0 treated as 1
//   i_start      in   1      start request; accepted only when o_busy=0
//   i_abort      in   1      stop the train immediately
//   o_busy       out  1      train in progress
//   o_pulse      out  1      pulse output, registered
//   o_remaining  out  WIDTH  pulses not yet completed
//   o_done       out  1      one-cycle strobe after the last pulse
//
// BEHAVIOUR
//   - Reset (async, any time, including mid-train):
//     - state=IDLE; all outputs 0 (o_busy, o_pulse, o_remaining, o_done).
//     - Phase counter cleared.
//   - FSM states: IDLE, HIGH, LOW. Every output is a register output.
//   - IDLE, on i_start=1 with N!=0:
//     - Latch N, H, L into internal registers.
//     - Next cycle: HIGH, o_busy=1, o_pulse=1, o_remaining=N.
//   - IDLE, on i_start=1 with N==0:
//     - No pulse; o_done=1 for the next cycle only; state stays IDLE.
//   - HIGH:
//     - o_pulse=1 for exactly H cycles.
//     - On the last cycle, o_remaining decrements (WIDTH-bit, no wrap possible).
//     - If the new remaining value is 0: go to IDLE. Next cycle o_busy=0,
//       o_pulse=0, o_done=1. No trailing low phase.
//     - Otherwise: go to LOW.
//   - LOW: o_pulse=0 for exactly L cycles, then HIGH.
//   - Total train length: N*H + (N-1)*L cycles; o_done follows in the next cycle.
//   - i_start while o_busy=1: ignored. Latched N/H/L unaffected.
//     Input changes mid-train have no effect.
//   - i_abort=1 (priority over everything except reset):
//     - Next cycle: state=IDLE, o_pulse=0, o_busy=0, o_done=0.
//     - o_remaining holds its value at abort.
//     - Same-cycle i_start is ignored.
//   - o_done is never asserted for two consecutive cycles.
//
// CONFIGURATION
//   PTG_CONTINUOUS_EN
//     - Defined: adds input port i_continuous (1 bit), sampled on start.
//       When latched at 1:
//       - o_remaining holds N and never decrements.
//       - HIGH/LOW alternate indefinitely until i_abort or reset.
//       - o_done is never asserted.
//     - Not defined: port absent; every train terminates after N pulses.
//
// TESTING
//   1. N=3, H=2, L=1, start pulse:
//      - o_pulse = 1,1,0,1,1,0,1,1 then 0.
//      - o_remaining = 3 -> 2 -> 1 -> 0.
//      - o_done=1 in cycle 9; o_busy low from cycle 9.
//   2. N=0, start:
//      - o_pulse stays 0; o_busy stays 0; o_done=1 for one cycle.
//   3. N=2, H=0, L=0:
//      - Treated as H=L=1: o_pulse = 1,0,1 then done.
//      - A start issued during the train is ignored.
//   4. N=5, H=3, L=3, abort during the 2nd high phase:
//      - Next cycle o_pulse=0, o_busy=0, o_remaining=4, no o_done.
//      - A following start with N=1 runs normally.
//   5. Reset asserted mid-LOW phase:
//      - All outputs 0 immediately (async), without waiting for a clock edge.
//      - After release, stays idle until the next start.
//   6. PTG_CONTINUOUS_EN defined, i_continuous=1, N=2, H=1, L=1:
//      - Toggles for 100 cycles with o_remaining=2 and no o_done.
//      - Abort returns it to IDLE.

Source files
------------

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - pulse-train generator: N pulses of H high / L low cycles, then a done strobe.
// Optional feature macro: PTG_CONTINUOUS_EN (adds i_continuous for free-running trains).
module pulse_train_gen #(
    parameter int WIDTH = 8,
    parameter int PER_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_count,
    input  logic [PER_W-1:0] i_high,
    input  logic [PER_W-1:0] i_low,
    input  logic             i_start,
    input  logic             i_abort,
`ifdef PTG_CONTINUOUS_EN
    input  logic             i_continuous,
`endif
    output logic             o_busy,
    output logic             o_pulse,
    output logic [WIDTH-1:0] o_remaining,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               pulse_q, pulse_d;
    logic [WIDTH-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;
    logic [PER_W-1:0]   phase_q, phase_d;
    logic [PER_W-1:0]   high_q, high_d;
    logic [PER_W-1:0]   low_q, low_d;
    logic               cont_q, cont_d;

    logic               cont_in;
    logic [PER_W-1:0]   high_eff;
    logic [PER_W-1:0]   low_eff;
    logic [WIDTH-1:0]   rem_dec;

`ifdef PTG_CONTINUOUS_EN
    assign cont_in = i_continuous;
`else
    assign cont_in = 1'b0;
`endif

    // Zero-length phases are stretched to one cycle so the train always advances.
    assign high_eff = (i_high == '0) ? PER_W'(1) : i_high;
    assign low_eff  = (i_low  == '0) ? PER_W'(1) : i_low;
    assign rem_dec  = remaining_q - WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pulse_d     = pulse_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        phase_d     = phase_q;
        high_d      = high_q;
        low_d       = low_q;
        cont_d      = cont_q;

        if (i_abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            pulse_d = 1'b0;
            phase_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_count != '0) begin
                            high_d      = high_eff;
                            low_d       = low_eff;
                            cont_d      = cont_in;
                            state_d     = HIGH;
                            busy_d      = 1'b1;
                            pulse_d     = 1'b1;
                            remaining_d = i_count;
                            phase_d     = high_eff - PER_W'(1);
                        end else if (!done_q && !cont_in) begin
                            // Guard keeps back-to-back empty starts from producing a two-cycle done.
                            done_d = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (phase_q == '0) begin
                        if (!cont_q && rem_dec == '0) begin
                            remaining_d = rem_dec;
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            pulse_d     = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            if (!cont_q) remaining_d = rem_dec;
                            state_d = LOW;
                            pulse_d = 1'b0;
                            phase_d = low_q - PER_W'(1);
                        end
                    end else begin
                        phase_d = phase_q - PER_W'(1);
                    end
                end
                LOW: begin
                    if (phase_q == '0) begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                        phase_d = high_q - PER_W'(1);
                    end else begin
                        phase_d = phase_q - PER_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pulse_d = 1'b0;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pulse_q     <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            phase_q     <= '0;
            high_q      <= PER_W'(1);
            low_q       <= PER_W'(1);
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pulse_q     <= pulse_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            phase_q     <= phase_d;
            high_q      <= high_d;
            low_q       <= low_d;
            cont_q      <= cont_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_pulse     = pulse_q;
    assign o_remaining = remaining_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen.
module tb_pulse_train_gen;

    typedef struct packed {
        logic       pulse;
        logic       busy;
        logic [7:0] rem;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] count = '0;
    logic [3:0] high = '0;
    logic [3:0] low = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
`ifdef PTG_CONTINUOUS_EN
    logic       cont = 1'b0;
`endif
    logic       o_busy, o_pulse, o_done;
    logic [7:0] o_remaining;

    exp_t sb[$];
    exp_t e, got;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pulse_train_gen #(.WIDTH(8), .PER_W(4)) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .i_count(count),
        .i_high(high),
        .i_low(low),
        .i_start(start),
        .i_abort(abort),
`ifdef PTG_CONTINUOUS_EN
        .i_continuous(cont),
`endif
        .o_busy(o_busy),
        .o_pulse(o_pulse),
        .o_remaining(o_remaining),
        .o_done(o_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs of a complete train, followed by the done cycle and one idle cycle.
    task automatic push_train(input int n, input int h, input int l);
        int he, le;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < he; c++) sb.push_back('{1'b1, 1'b1, 8'(n - k), 1'b0});
            if (k < n - 1)
                for (int c = 0; c < le; c++) sb.push_back('{1'b0, 1'b1, 8'(n - k - 1), 1'b0});
        end
        sb.push_back('{1'b0, 1'b0, 8'd0, 1'b1});
        sb.push_back('{1'b0, 1'b0, 8'd0, 1'b0});
    endtask

    task automatic test_reset();
        #2;
        got = {o_pulse, o_busy, o_remaining, o_done};
        vectors++;
        if (got !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_async got %h exp %h", got, 11'd0);
        end
        step();
        step();
        got = {o_pulse, o_busy, o_remaining, o_done};
        vectors++;
        if (got !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_held got %h exp %h", got, 11'd0);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int cyc = 1;
        push_train(3, 2, 1);
        count = 8'd3; high = 4'd2; low = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL basic cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            cyc++;
            step();
        end
    endtask

    task automatic test_min_phase();
        int cyc = 1;
        push_train(2, 0, 0);
        count = 8'd2; high = 4'd0; low = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL min_phase cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            // Mid-train start with new parameters must be ignored.
            start = (cyc == 1);
            if (cyc == 1) begin count = 8'd7; high = 4'd5; low = 4'd5; end
            cyc++;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_zero_count();
        int cyc = 1;
        sb.push_back('{1'b0, 1'b0, 8'd0, 1'b1});
        sb.push_back('{1'b0, 1'b0, 8'd0, 1'b0});
        sb.push_back('{1'b0, 1'b0, 8'd0, 1'b0});
        count = 8'd0; high = 4'd2; low = 4'd2; start = 1'b1;
        step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL zero_count cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            start = 1'b0;
            cyc++;
            step();
        end
    endtask

    task automatic test_abort();
        int cyc = 1;
        push_train(5, 3, 3);
        while (sb.size() > 8) void'(sb.pop_back());
        sb.push_back('{1'b0, 1'b0, 8'd4, 1'b0});
        sb.push_back('{1'b0, 1'b0, 8'd4, 1'b0});
        count = 8'd5; high = 4'd3; low = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL abort cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            // Abort in the middle of the second high phase, with a competing start.
            abort = (cyc == 8);
            start = (cyc == 8);
            if (cyc == 8) count = 8'd1;
            cyc++;
            step();
        end
        abort = 1'b0;
        start = 1'b0;
        cyc = 1;
        push_train(1, 1, 1);
        count = 8'd1; high = 4'd1; low = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL after_abort cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            cyc++;
            step();
        end
    endtask

    task automatic test_async_reset();
        int cyc = 1;
        push_train(3, 2, 4);
        while (sb.size() > 3) void'(sb.pop_back());
        count = 8'd3; high = 4'd2; low = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL pre_reset cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            cyc++;
            if (sb.size() > 0) step();
        end
        // Now in the first low phase; reset must clear outputs before any clock edge.
        rstn = 1'b0;
        #1;
        got = {o_pulse, o_busy, o_remaining, o_done};
        vectors++;
        if (got !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h exp %h", got, 11'd0);
        end
        step();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== 11'd0) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc%0d got %h exp %h", i, got, 11'd0);
            end
        end
    endtask

`ifdef PTG_CONTINUOUS_EN
    task automatic test_continuous();
        for (int i = 0; i < 100; i++)
            sb.push_back('{(i % 2 == 0), 1'b1, 8'd2, 1'b0});
        sb.push_back('{1'b0, 1'b0, 8'd2, 1'b0});
        count = 8'd2; high = 4'd1; low = 4'd1; cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        cont = 1'b0;
        for (int cyc = 1; sb.size() > 0; cyc++) begin
            e = sb.pop_front();
            got = {o_pulse, o_busy, o_remaining, o_done};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL continuous cyc%0d pulse/busy/rem/done got %b/%b/%0d/%b exp %b/%b/%0d/%b",
                         cyc, got.pulse, got.busy, got.rem, got.done, e.pulse, e.busy, e.rem, e.done);
            end
            abort = (cyc == 100);
            step();
        end
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_min_phase();
        test_zero_count();
        test_abort();
        test_async_reset();
`ifdef PTG_CONTINUOUS_EN
        test_continuous();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
